// File: rtl/blkchk_session_arbiter.sv
// Round-robin session arbiter that time-shares one begin/end block checker between N_REQ byte streams.
// Optional macro BLKCHK_IDLE_ABORT_EN adds a stall-timeout abort and the done_abort output.
module blkchk_session_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GRANT_W    = 2,
  parameter int IDLE_LIMIT = 64
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     done_valid,
  output logic                 done_result,
`ifdef BLKCHK_IDLE_ABORT_EN
  output logic                 done_abort,
`endif
  output logic                 busy,
  output logic [GRANT_W-1:0]   grant_idx,
  output logic                 chk_clr,
  output logic                 chk_en,
  output logic [7:0]           chk_in,
  input  logic                 chk_result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_PRIME = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_FL1   = 3'd4;
  localparam logic [2:0] S_FL2   = 3'd5;
  localparam logic [2:0] S_REP   = 3'd6;

  logic [2:0]                state;
  logic [GRANT_W-1:0]        rr;
  logic [GRANT_W-1:0]        pick;
  logic [GRANT_W-1:0]        rr_next;
  logic                      any;
  logic [2*N_REQ-1:0]        dbl;
  logic [N_REQ-1:0]          rot;
  logic [N_REQ-1:0][7:0]     data_a;
  logic                      gvalid, glast;
  logic [7:0]                gdata;
  logic                      feed, accept, abort_go, aborted;
  int                        tmp;

  assign data_a = req_data;
  assign gvalid = req_valid[grant_idx];
  assign glast  = req_last[grant_idx];
  assign gdata  = data_a[grant_idx];
  assign feed   = (state == S_FEED);
  assign accept = feed && gvalid;

  // Rotate the request vector so bit 0 is the rr pointer; the lowest set bit wins.
  assign dbl = {req_valid, req_valid} >> rr;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    pick = rr;
    any  = 1'b0;
    tmp  = 0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) begin
        tmp = int'(rr) + i;
        if (tmp >= N_REQ) tmp = tmp - N_REQ;
        pick = GRANT_W'(tmp);
        any  = 1'b1;
      end
    end
  end

  assign rr_next = (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;

`ifdef BLKCHK_IDLE_ABORT_EN
  localparam int SW = $clog2(IDLE_LIMIT+1);
  logic [SW-1:0] stall_cnt;

  // Fires on the IDLE_LIMIT-th consecutive stall cycle.
  assign abort_go = feed && !gvalid && (stall_cnt == SW'(IDLE_LIMIT-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      aborted   <= 1'b0;
    end else begin
      if (state == S_PRIME || accept) stall_cnt <= '0;
      else if (feed)                  stall_cnt <= stall_cnt + 1'b1;
      if (state == S_CLR)             aborted   <= 1'b0;
      else if (abort_go)              aborted   <= 1'b1;
    end
  end

  assign done_abort = (state == S_REP) && aborted;
`else
  assign abort_go = 1'b0;
  assign aborted  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      rr        <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (any) begin
          grant_idx <= pick;
          state     <= S_CLR;
        end
        S_CLR:   state <= S_PRIME;
        S_PRIME: state <= S_FEED;
        S_FEED: begin
          if (accept && glast) state <= S_FL1;
          else if (abort_go)   state <= S_REP;
        end
        S_FL1:   state <= S_FL2;
        S_FL2:   state <= S_REP;
        S_REP: begin
          rr    <= rr_next;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign req_ready[i]  = feed && (grant_idx == GRANT_W'(i));
    assign done_valid[i] = (state == S_REP) && (grant_idx == GRANT_W'(i));
  end

  assign busy        = (state != S_IDLE);
  assign chk_clr     = (state == S_CLR);
  assign chk_en      = (state == S_PRIME) || (state == S_FL1) || (state == S_FL2) || accept;
  assign chk_in      = !chk_en ? 8'h00 : (feed ? gdata : 8'h20);
  assign done_result = (state == S_REP) && chk_result && !aborted;

endmodule

// File: tb/tb_blkchk_session_arbiter.sv
// Directed bench for blkchk_session_arbiter with a behavioural begin/end checker on the chk_* side.
module tb_blkchk_session_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid, req_last, req_ready, done_valid;
  logic [31:0] req_data;
  logic        done_result, busy, chk_clr, chk_en, chk_result;
  logic [1:0]  grant_idx;
  logic [7:0]  chk_in;

  logic        v [4];
  logic        l [4];
  logic [7:0]  d [4];
  int          last_cyc [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req_valid = {v[3], v[2], v[1], v[0]};
  assign req_last  = {l[3], l[2], l[1], l[0]};
  assign req_data  = {d[3], d[2], d[1], d[0]};

  blkchk_session_arbiter #(.N_REQ(4), .GRANT_W(2), .IDLE_LIMIT(64)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .done_valid(done_valid), .done_result(done_result), .busy(busy), .grant_idx(grant_idx),
    .chk_clr(chk_clr), .chk_en(chk_en), .chk_in(chk_in), .chk_result(chk_result)
  );

  // Word-level checker: "begin" +1, "end" -1, fails if the count ever dips below zero.
  logic [39:0] wbuf;
  int          wl, cnt;
  logic        ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || chk_clr) begin
      wbuf <= '0; wl <= 0; cnt <= 0; ok <= 1'b1;
    end else if (chk_en) begin
      if (chk_in == 8'h20) begin
        wl <= 0;
        if (wl == 5 && wbuf == 40'h626567696e) cnt <= cnt + 1;
        else if (wl == 3 && wbuf[23:0] == 24'h656e64) begin
          cnt <= cnt - 1;
          if (cnt == 0) ok <= 1'b0;
        end
      end else begin
        wbuf <= {wbuf[31:0], chk_in};
        if (wl < 6) wl <= wl + 1;
      end
    end
  end
  assign chk_result = ok && (cnt == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] dq_mask [$];
  logic       dq_res  [$];
  int         dq_cyc  [$];
  int en_cnt = 0, sp_cnt = 0, clr_cnt = 0, bad_idle = 0;
  always @(negedge clk) begin
    if (done_valid != 4'b0) begin
      dq_mask.push_back(done_valid);
      dq_res.push_back(done_result);
      dq_cyc.push_back(cyc);
    end
    if (!chk_en && chk_in != 8'h00) bad_idle <= bad_idle + 1;
    if (chk_en) en_cnt <= en_cnt + 1;
    if (chk_en && chk_in == 8'h20) sp_cnt <= sp_cnt + 1;
    if (chk_clr) clr_cnt <= clr_cnt + 1;
  end

  // Present string s on requester r, optionally dropping valid for sn cycles before byte sa.
  task automatic drive(input int r, input string s, input int sa, input int sn);
    int t;
    for (int i = 0; i < s.len(); i++) begin
      if (i == sa) begin
        v[r] = 1'b0;
        repeat (sn) begin @(posedge clk); #1; end
      end
      v[r] = 1'b1; d[r] = s[i]; l[r] = (i == s.len()-1);
      t = 0;
      do begin @(negedge clk); t++; end while (!req_ready[r] && t < 200);
      tests++;
      if (req_ready[r] !== 1'b1) begin
        fails++; $display("FAIL handshake req%0d byte %0d: ready=%b, required 1", r, i, req_ready[r]);
      end
      if (i == s.len()-1) last_cyc[r] = cyc;
      @(posedge clk); #1;
    end
    v[r] = 1'b0; l[r] = 1'b0; d[r] = 8'h00;
  endtask

  task automatic wait_n(input int n);
    for (int t = 0; t < 100 && dq_mask.size() < n; t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, req_ready, done_valid, done_result, grant_idx, chk_clr, chk_en, chk_in} !== 22'd0) begin
      fails++; $display("FAIL reset_outputs: got %h, required 0",
                        {busy, req_ready, done_valid, done_result, grant_idx, chk_clr, chk_en, chk_in});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || grant_idx !== 2'd0) begin
      fails++; $display("FAIL reset_release: busy=%b grant=%0d, required 0/0", busy, grant_idx);
    end
  endtask

  task automatic test_rr_all;
    int b;
    b = dq_mask.size();
    @(posedge clk); #1;
    fork
      drive(0, "begin", -1, 0);
      drive(1, "begin", -1, 0);
      drive(2, "begin", -1, 0);
      drive(3, "begin", -1, 0);
    join
    wait_n(b + 4);
    tests++;
    if (dq_mask.size() != b + 4) begin
      fails++; $display("FAIL rr_count: got %0d done pulses, required 4", dq_mask.size() - b);
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (dq_mask[b+k] !== 4'(1 << k) || dq_res[b+k] !== 1'b0) begin
          fails++; $display("FAIL rr_order %0d: mask=%b res=%b, required %b/0", k, dq_mask[b+k], dq_res[b+k], 4'(1 << k));
        end
        if (k < 3) begin
          tests++;
          if (dq_cyc[b+k+1] - dq_cyc[b+k] != 11) begin
            fails++; $display("FAIL rr_gap %0d: got %0d cycles, required 11", k, dq_cyc[b+k+1] - dq_cyc[b+k]);
          end
        end
      end
    end
  endtask

  task automatic test_basic;
    int b;
    b = dq_mask.size();
    @(posedge clk); #1;
    v[0] = 1'b1; d[0] = "b"; l[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: busy=%b, required 0", busy); end
    @(negedge clk);
    tests++;
    if (chk_clr !== 1'b1 || grant_idx !== 2'd0 || req_ready !== 4'b0 || chk_en !== 1'b0) begin
      fails++; $display("FAIL basic_clr: clr=%b grant=%0d ready=%b en=%b, required 1/0/0000/0", chk_clr, grant_idx, req_ready, chk_en);
    end
    @(negedge clk);
    tests++;
    if (chk_en !== 1'b1 || chk_in !== 8'h20 || chk_clr !== 1'b0 || req_ready !== 4'b0) begin
      fails++; $display("FAIL basic_prime: en=%b in=%h clr=%b ready=%b, required 1/20/0/0000", chk_en, chk_in, chk_clr, req_ready);
    end
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001 || chk_en !== 1'b1 || chk_in !== 8'h62) begin
      fails++; $display("FAIL basic_feed: ready=%b en=%b in=%h, required 0001/1/62", req_ready, chk_en, chk_in);
    end
    @(posedge clk); #1;
    drive(0, "egin end", -1, 0);
    wait_n(b + 1);
    tests++;
    if (dq_mask.size() != b + 1) begin
      fails++; $display("FAIL basic_count: got %0d pulses, required 1", dq_mask.size() - b);
    end else begin
      tests++;
      if (dq_mask[b] !== 4'b0001 || dq_res[b] !== 1'b1) begin
        fails++; $display("FAIL basic_done: mask=%b res=%b, required 0001/1", dq_mask[b], dq_res[b]);
      end
      tests++;
      if (dq_cyc[b] - last_cyc[0] != 3) begin
        fails++; $display("FAIL basic_latency: got %0d, required 3", dq_cyc[b] - last_cyc[0]);
      end
    end
  endtask

  task automatic test_clr_between;
    int b, c0;
    b = dq_mask.size(); c0 = clr_cnt;
    drive(1, "end begin", -1, 0);
    wait_n(b + 1);
    drive(1, "begin end", -1, 0);
    wait_n(b + 2);
    tests++;
    if (dq_mask.size() != b + 2) begin
      fails++; $display("FAIL clr_count: got %0d pulses, required 2", dq_mask.size() - b);
    end else begin
      tests++;
      if (dq_mask[b] !== 4'b0010 || dq_res[b] !== 1'b0) begin
        fails++; $display("FAIL clr_first: mask=%b res=%b, required 0010/0", dq_mask[b], dq_res[b]);
      end
      tests++;
      if (dq_mask[b+1] !== 4'b0010 || dq_res[b+1] !== 1'b1) begin
        fails++; $display("FAIL clr_second: mask=%b res=%b, required 0010/1", dq_mask[b+1], dq_res[b+1]);
      end
    end
    tests++;
    if (clr_cnt - c0 != 2) begin
      fails++; $display("FAIL clr_pulses: got %0d, required 2", clr_cnt - c0);
    end
  endtask

  task automatic test_stall;
    int b, e0, s0;
    b = dq_mask.size(); e0 = en_cnt; s0 = sp_cnt;
    drive(2, "begin end", 3, 5);
    wait_n(b + 1);
    tests++;
    if (dq_mask.size() != b + 1) begin
      fails++; $display("FAIL stall_count: got %0d pulses, required 1", dq_mask.size() - b);
    end else begin
      tests++;
      if (dq_mask[b] !== 4'b0100 || dq_res[b] !== 1'b1) begin
        fails++; $display("FAIL stall_done: mask=%b res=%b, required 0100/1", dq_mask[b], dq_res[b]);
      end
      tests++;
      if (dq_cyc[b] - last_cyc[2] != 3) begin
        fails++; $display("FAIL stall_latency: got %0d, required 3", dq_cyc[b] - last_cyc[2]);
      end
    end
    tests++;
    if (en_cnt - e0 != 12 || sp_cnt - s0 != 4) begin
      fails++; $display("FAIL stall_enables: en=%0d spaces=%0d, required 12/4", en_cnt - e0, sp_cnt - s0);
    end
  endtask

  task automatic test_reset_mid;
    int b, c0, t;
    b = dq_mask.size();
    @(posedge clk); #1;
    v[3] = 1'b1; d[3] = "b"; l[3] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[3] && t < 50);
    tests++;
    if (req_ready[3] !== 1'b1) begin fails++; $display("FAIL rmid_grant: ready=%b, required 1", req_ready[3]); end
    @(posedge clk); #1 d[3] = "e";
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, req_ready, done_valid, done_result, grant_idx, chk_clr, chk_en, chk_in} !== 22'd0) begin
      fails++; $display("FAIL rmid_outputs: got %h, required 0",
                        {busy, req_ready, done_valid, done_result, grant_idx, chk_clr, chk_en, chk_in});
    end
    v[3] = 1'b0; d[3] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (dq_mask.size() != b || busy !== 1'b0) begin
      fails++; $display("FAIL rmid_silent: pulses=%0d busy=%b, required 0/0", dq_mask.size() - b, busy);
    end
    c0 = clr_cnt;
    drive(3, "endx", -1, 0);
    wait_n(b + 1);
    tests++;
    if (dq_mask.size() != b + 1) begin
      fails++; $display("FAIL rmid_count: got %0d pulses, required 1", dq_mask.size() - b);
    end else begin
      tests++;
      if (dq_mask[b] !== 4'b1000 || dq_res[b] !== 1'b1) begin
        fails++; $display("FAIL rmid_done: mask=%b res=%b, required 1000/1", dq_mask[b], dq_res[b]);
      end
    end
    tests++;
    if (clr_cnt - c0 != 1) begin fails++; $display("FAIL rmid_clr: got %0d, required 1", clr_cnt - c0); end
  endtask

  task automatic test_chk_idle;
    tests++;
    if (bad_idle != 0) begin
      fails++; $display("FAIL chk_in_idle: %0d cycles with chk_in!=0 while chk_en=0, required 0", bad_idle);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; d[i] = 8'h00; last_cyc[i] = 0;
    end
    test_reset;
    test_rr_all;
    test_basic;
    test_clr_between;
    test_stall;
    test_reset_mid;
    test_chk_idle;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
